// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in/serial-out shifter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CIRC    = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Word-load handshake and serial output bundle of the PISO shifter.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 7
);

  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] datain;
  logic             dataout;
  logic             out_valid;
  logic             frame_start;
  logic             done;

  // Producer side: offers words, observes the serial stream.
  modport master (
    output mode, in_valid, datain,
    input  in_ready, dataout, out_valid, frame_start, done
  );

  // Shifter side.
  modport slave (
    input  mode, in_valid, datain,
    output in_ready, dataout, out_valid, frame_start, done
  );

endinterface

// File: rtl/shift_bit_counter.sv
// Bit position within the current frame; saturates at LIMIT and only returns
// to zero through an explicit clear.
module shift_bit_counter #(
  parameter int unsigned CNT_W = 3,
  parameter int unsigned LIMIT = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             at_limit
);

  logic [CNT_W-1:0] count_q;

  assign count    = count_q;
  assign at_limit = (count_q == CNT_W'(LIMIT));

  // Clear wins over enable; the count holds once it reaches LIMIT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !at_limit) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parametrised parallel-in/serial-out shifter with valid/ready word loading,
// gap-free back-to-back framing and an optional circular repeat mode.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 7,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst,
  piso_serializer_if.slave  bus
);

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic [WIDTH-1:0] shadow_q;
  logic             mode_q;
  logic             dataout_q;
  logic             out_valid_q;
  logic             frame_start_q;
  logic             done_q;

  logic [CNT_W-1:0] count;
  logic             at_limit;
  logic             in_ready;
  logic             accept;
  logic             shifting;
  logic             head;

  // A new word can only enter while idle or on the last bit of a frame.
  assign shifting = (state_q == SHIFT);
  assign in_ready = (state_q == IDLE) || (shifting && at_limit);
  assign accept   = bus.in_valid && in_ready;
  assign head     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  // Next contents of the shift register after one bit leaves the head.
  always_comb begin
    shift_d = shift_q;
    if (MSB_FIRST) begin
      shift_d = {shift_q[WIDTH-2:0], 1'b0};
    end else begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Counter restarts whenever a frame (re)starts or the block sits idle.
  shift_bit_counter #(
    .CNT_W (CNT_W),
    .LIMIT (WIDTH - 1)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    (in_ready),
    .enable   (shifting),
    .count    (count),
    .at_limit (at_limit)
  );

  // Framing FSM, shift/shadow registers and registered serial outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      shadow_q      <= '0;
      mode_q        <= MODE_ONESHOT;
      dataout_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      out_valid_q   <= shifting;
      dataout_q     <= shifting && head;
      frame_start_q <= shifting && (count == '0);
      done_q        <= shifting && at_limit;

      if (accept) begin
        shift_q  <= bus.datain;
        shadow_q <= bus.datain;
        mode_q   <= bus.mode;
        state_q  <= SHIFT;
      end else if (shifting) begin
        if (!at_limit) begin
          shift_q <= shift_d;
        end else if (mode_q == MODE_CIRC) begin
          shift_q <= shadow_q;
        end else begin
          state_q <= IDLE;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.dataout     = dataout_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance
// run in lock-step; frames are queued on acceptance and popped per output bit.
module tb_piso_serializer;
  import piso_pkg::*;

  localparam int unsigned W = 7;

  typedef struct packed {
    logic dm;   // expected bit, MSB-first instance
    logic dl;   // expected bit, LSB-first instance
    logic fs;
    logic dn;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst_n),
    .bus (bus_l)
  );

  always #5 clk = ~clk;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp     = 0;
  int          n_fail    = 0;
  bit          mon_en    = 1'b0;
  bit          prev_done = 1'b0;

  // Reference model of the word-level control
  bit          m_busy    = 1'b0;
  int unsigned m_cnt     = 0;
  logic        m_circ    = MODE_ONESHOT;
  logic [W-1:0] m_shadow = '0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic md);
    bus_m.in_valid = v;  bus_m.datain = d;  bus_m.mode = md;
    bus_l.in_valid = v;  bus_l.datain = d;  bus_l.mode = md;
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    exp_t e;
    for (int k = 0; k < int'(W); k++) begin
      e.dm = w[W-1-k];
      e.dl = w[k];
      e.fs = (k == 0);
      e.dn = (k == int'(W) - 1);
      sb_q.push_back(e);
    end
  endtask

  // One clock: check in_ready against the model, update the model for the
  // coming edge, then advance to just after the following falling edge.
  task automatic tick(output bit accepted);
    logic exp_rdy;
    exp_rdy = !m_busy || (m_cnt == W - 1);
    chk("in_ready_msb", bus_m.in_ready, exp_rdy);
    chk("in_ready_lsb", bus_l.in_ready, exp_rdy);
    accepted = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;  m_cnt = 0;  m_circ = MODE_ONESHOT;  m_shadow = '0;
    end else if (bus_m.in_valid && exp_rdy) begin
      push_frame(bus_m.datain);
      m_shadow = bus_m.datain;
      m_circ   = bus_m.mode;
      m_busy   = 1'b1;
      m_cnt    = 0;
      accepted = 1'b1;
    end else if (m_busy && m_cnt == W - 1) begin
      if (m_circ == MODE_CIRC) begin
        push_frame(m_shadow);
        m_cnt = 0;
      end else begin
        m_busy = 1'b0;
      end
    end else if (m_busy) begin
      m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    bit acc;
    repeat (n) tick(acc);
  endtask

  task automatic send(input logic [W-1:0] w, input logic md);
    bit acc;
    acc = 1'b0;
    drive(1'b1, w, md);
    for (int i = 0; i < 64 && !acc; i++) tick(acc);
    chk("send_accepted", acc, 1'b1);
    drive(1'b0, w, md);
  endtask

  task automatic wait_idle();
    bit acc;
    for (int i = 0; i < 200 && m_busy; i++) tick(acc);
    chk("reach_idle", m_busy, 1'b0);
    run(2);
  endtask

  // Output monitor: pop one expected bit per valid cycle, idle outputs at 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_done && sb_q.size() != 0) chk("no_gap", bus_m.out_valid, 1'b1);
      if (bus_m.out_valid === 1'b1) begin
        chk("sb_has_entry", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("dataout_msb",     bus_m.dataout,     mon_e.dm);
          chk("frame_start_msb", bus_m.frame_start, mon_e.fs);
          chk("done_msb",        bus_m.done,        mon_e.dn);
          chk("out_valid_lsb",   bus_l.out_valid,   1'b1);
          chk("dataout_lsb",     bus_l.dataout,     mon_e.dl);
          chk("frame_start_lsb", bus_l.frame_start, mon_e.fs);
          chk("done_lsb",        bus_l.done,        mon_e.dn);
        end
      end else begin
        chk("idle_valid_msb",   bus_m.out_valid,   1'b0);
        chk("idle_valid_lsb",   bus_l.out_valid,   1'b0);
        chk("idle_dataout_msb", bus_m.dataout,     1'b0);
        chk("idle_dataout_lsb", bus_l.dataout,     1'b0);
        chk("idle_fs_msb",      bus_m.frame_start, 1'b0);
        chk("idle_done_msb",    bus_m.done,        1'b0);
      end
      prev_done = (bus_m.done === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    drive(1'b0, '0, MODE_ONESHOT);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_out_valid",   bus_m.out_valid,   1'b0);
    chk("rst_dataout",     bus_m.dataout,     1'b0);
    chk("rst_frame_start", bus_m.frame_start, 1'b0);
    chk("rst_done",        bus_m.done,        1'b0);
    chk("rst_in_ready",    bus_m.in_ready,    1'b1);
    mon_en = 1'b1;

    // One-shot frame
    send(7'b1110101, MODE_ONESHOT);
    wait_idle();

    // Back-to-back: second word offered until the last-bit cycle
    send(7'b1110101, MODE_ONESHOT);
    send(7'b0000001, MODE_ONESHOT);
    wait_idle();

    // Circular; mode and datain changes mid-stream must be ignored
    send(7'b1110101, MODE_CIRC);
    drive(1'b0, 7'b1010101, MODE_ONESHOT);
    run(3 * W + 2);
    send(7'b0101010, MODE_ONESHOT);
    wait_idle();

    // Reset during bit 3 discards the rest of the frame
    send(7'b1011001, MODE_ONESHOT);
    run(4);
    rst_n = 1'b0;
    sb_q.delete();
    tick(acc);
    chk("midrst_out_valid_msb", bus_m.out_valid, 1'b0);
    chk("midrst_dataout_msb",   bus_m.dataout,   1'b0);
    chk("midrst_done_msb",      bus_m.done,      1'b0);
    chk("midrst_out_valid_lsb", bus_l.out_valid, 1'b0);
    chk("midrst_done_lsb",      bus_l.done,      1'b0);
    rst_n = 1'b1;
    tick(acc);
    send(7'b0110011, MODE_ONESHOT);
    wait_idle();

    // in_valid held high with changing data: only the word on the
    // last-bit cycle is taken
    send(7'b1100110, MODE_ONESHOT);
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      drive(1'b1, W'($urandom), MODE_ONESHOT);
      tick(acc);
    end
    chk("hold_accepted", acc, 1'b1);
    drive(1'b0, '0, MODE_ONESHOT);
    wait_idle();

    chk("sb_drained", sb_q.size() == 0, 1'b1);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
